// File: rtl/run_len_detect.sv
// Run-length detector: flags N identical consecutive enabled samples of S,
// with polarity select, a per-run hit pulse and a saturating detection counter.
module run_len_detect #(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             S,
  input  logic [1:0]       mode,
  output logic             Y,
  output logic             hit,
  output logic [CNT_W-1:0] run_cnt,
  output logic             last,
  output logic [CNT_W-1:0] det_cnt
);

  localparam int unsigned   EXT_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [EXT_W-1:0] RUN_LEN_E = EXT_W'(RUN_LEN);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
  logic             last_q, last_d;
  logic             hit_q, hit_d;

  logic             allow_s;
  logic [EXT_W-1:0] cnt_p1;
  logic [CNT_W-1:0] next_cnt;
  logic             qual;
  logic             run_ok;

  // Polarity qualification of the current sample
  always_comb begin
    allow_s = 1'b0;
    case (mode)
      2'b00:   allow_s = 1'b1;
      2'b01:   allow_s = S;
      2'b10:   allow_s = ~S;
      default: allow_s = 1'b0;
    endcase
  end

  // Extended-width increment doubles as overflow flag and as the Y threshold test
  always_comb begin
    cnt_p1   = {1'b0, run_cnt_q} + EXT_W'(1);
    next_cnt = CNT_W'(1);
    if ((run_cnt_q != '0) && (S == last_q)) begin
      next_cnt = cnt_p1[CNT_W] ? CNT_MAX : cnt_p1[CNT_W-1:0];
    end
    qual   = (next_cnt == RUN_LEN_C) && allow_s;
    run_ok = (cnt_p1 >= RUN_LEN_E) && (S == last_q);
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    det_cnt_d = det_cnt_q;
    last_d    = last_q;
    hit_d     = 1'b0;
    if (clr) begin
      run_cnt_d = '0;
      det_cnt_d = '0;
    end else if (en) begin
      run_cnt_d = next_cnt;
      last_d    = S;
      hit_d     = qual;
      if (qual && (det_cnt_q != CNT_MAX)) begin
        det_cnt_d = det_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
      det_cnt_q <= '0;
      last_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      det_cnt_q <= det_cnt_d;
      last_q    <= last_d;
      hit_q     <= hit_d;
    end
  end

  assign Y       = en & allow_s & ((RUN_LEN == 1) | run_ok);
  assign hit     = hit_q;
  assign run_cnt = run_cnt_q;
  assign last    = last_q;
  assign det_cnt = det_cnt_q;

endmodule
